sl_rx_ctrl: RTL and testbench
=============================

# sl_rx_ctrl

Receive-side controller for the Sl serial receiver in the Sl-to-APB bridge. It arms and configures the receiver and synchronises its word-complete handshake into the `clk` domain. Each finished word is validated, right-aligned and pushed into a small FIFO that the APB register side drains. Rejected words are counted and overflow is flagged, so the bus side never has to handle the receiver directly.

## Interface
- `FIFO_DEPTH`, 4: word FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, 8: width of the saturating error counters.
- `clk` in 1: system/APB clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfgEnable` in 1: reception enabled.
- `cfgBitCount` in 5: word length minus 1 (7 = 8-bit word).
- `rxEnable` out 1: drives receiver `enable`.
- `rxBitCount` out 5: drives receiver `bitCount`.
- `rxWordInProces` in 1: receiver busy; asynchronous to `clk`.
- `rxWordReady` in 1: receiver word complete; asynchronous to `clk`.
- `rxData` in 32: receiver `dataOut`; MSB-aligned, word in `[31:31-bitCount]`.
- `rxParityValid` in 1: parity check of the completed word.
- `rxBitCountValid` in 1: length check of the completed word.
- `rdData` out 32: FIFO head, right-aligned, upper bits zero.
- `rdValid` out 1: FIFO not empty.
- `rdReady` in 1: pop; takes effect only when `rdValid` is high.
- `fifoLevel` out $clog2(FIFO_DEPTH)+1: current entry count.
- `parityErrCnt` out CNT_W: words dropped for parity; saturates at all-ones.
- `lenErrCnt` out CNT_W: words dropped for length; saturates at all-ones.
- `overflowErr` out 1: sticky; a valid word was dropped because the FIFO was full.
- `errClear` in 1: one-cycle pulse; clears both counters and `overflowErr`.
- `irq` out 1: registered; equals `rdValid | overflowErr` one cycle late.

## Operation
- **Synchronisation.** `rxWordInProces` and `rxWordReady` each pass through 2-flop synchronisers. A rising-edge detect on the synchronised `rxWordReady` produces `wordEvt`.
- **State IDLE.** `rxEnable`=0. Go to ARMED when `cfgEnable`=1; `rxBitCount` loads `cfgBitCount` on that transition.
- **State ARMED.**
  - `rxEnable`=1.
  - Go to BUSY on synchronised `rxWordInProces`=1.
  - Go to CAPTURE on `wordEvt`; this path covers short words where the busy flag was missed.
  - `rxBitCount` tracks `cfgBitCount` every cycle.
- **State BUSY.**
  - `rxBitCount` is frozen; cfg changes are deferred to the next ARMED.
  - `wordEvt` leads to CAPTURE.
- **State CAPTURE (one cycle).**
  - Sample `rxData`, `rxParityValid` and `rxBitCountValid`.
  - Right-align: `aligned = rxData >> (31 - rxBitCount)`.
  - Then go to ARMED, or to IDLE if `cfgEnable`=0.
- **Disable.** `cfgEnable`=0 in ARMED or BUSY goes to IDLE the next cycle and drops `rxEnable`. A word in flight is discarded and no counter changes.
- **Validation in CAPTURE.**
  - Both flags valid: push `aligned`.
  - Parity invalid: `parityErrCnt`+1.
  - Length invalid: `lenErrCnt`+1.
  - Both invalid: both counters increment. Invalid words are never pushed.
- **FIFO full.**
  - A valid push with no pop in the same cycle is dropped and sets `overflowErr`.
  - Push and pop in the same cycle while full: both happen, level unchanged, no overflow.
- **Empty.** `rdReady` with `rdValid`=0 is ignored.
- **errClear.** A simultaneous `errClear` and error increment yields 0; clear wins. Clear does not affect FIFO contents.
- **Reset values.** All outputs 0, state IDLE, FIFO empty, counters 0.

## Timing
- `rxWordReady` first sampled high at edge N:
  - `wordEvt` after edge N+1.
  - CAPTURE during cycle N+2.
  - FIFO write at edge N+3; `rdValid`/`fifoLevel` update after N+3.
  - `irq` updates after N+4.
- The receiver must hold `rxData` and the valid flags stable for at least 4 `clk` cycles after `rxWordReady` rises. This is a system constraint on Sl bit rate versus `clk`.
- `rxWordReady` must be low for at least 2 `clk` cycles between words.
- Pop is first-word-fall-through: `rdData` shows the head combinationally from the FIFO registers, and advances at the edge where `rdValid & rdReady`.
- Asynchronous reset mid-operation: immediate return to reset values. The next `wordEvt` requires a fresh rising edge after deassertion.

## Structure
- Package `sl_pkg`:
  - state enum `sl_rx_state_t` {IDLE, ARMED, BUSY, CAPTURE}
  - `SL_WORD_W`=32
  - `SL_CNT_W_DEF`=8
- Sub-module `sl_rx_fifo`: parameterised synchronous FIFO with a count output and simultaneous push/pop while full.
- The synchronisers and the FSM stay in the top level.

## Test plan
- `cfgBitCount`=7, `rxData`=0xA500_0000, both valid -> `rdData`=0x0000_00A5, `fifoLevel`=1, `rdValid` at N+3, `irq` at N+4.
- `cfgBitCount`=14, `rxData`=0xB554_0000 (15-bit 0x5AAA) -> `rdData`=0x0000_5AAA; pop -> `fifoLevel`=0 and `irq` clears.
- `rxParityValid`=0 word -> no push, `parityErrCnt`=1. Then a word with both flags invalid -> `parityErrCnt`=2, `lenErrCnt`=1.
- 5 valid words (1..5) with no pops -> `fifoLevel`=4, `overflowErr`=1, pops return 1,2,3,4. `errClear` -> all error outputs 0.
- `cfgEnable`=0 while BUSY -> `rxEnable`=0 next cycle, no push, counters unchanged. Re-enable with `cfgBitCount`=3 -> `rxBitCount`=3.
- Full FIFO with push and pop in the same cycle -> level stays 4, `overflowErr`=0. `reset_n` pulse mid-word -> all outputs 0.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared types and constants for the Sl receive path.
package sl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        BUSY    = 2'd2,
        CAPTURE = 2'd3
    } sl_rx_state_t;

    localparam int SL_WORD_W    = 32;
    localparam int SL_CNT_W_DEF = 8;

    // The receiver MSB-aligns a (bitCount+1)-bit word; move it down to bit 0.
    function automatic logic [SL_WORD_W-1:0] slAlign(
        input logic [SL_WORD_W-1:0] data,
        input logic [4:0]           bitCount
    );
        return data >> (5'd31 - bitCount);
    endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Small synchronous word FIFO, first-word-fall-through, with an entry count.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sl_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       popData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   notEmpty,
    output logic                   dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign full     = (count == FULL_COUNT);
    assign notEmpty = (count != '0);
    assign doPop    = pop & notEmpty;
    assign doPush   = push & (~full | doPop);
    assign dropped  = push & ~doPush;

    // Head is shown straight from storage; forced to zero while empty.
    assign popData  = notEmpty ? mem[rdPtr] : '0;

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Word storage.
    // NOTE: the data array has no reset; the count already marks every entry invalid after reset.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/sl_rx_ctrl.sv
// Receive-side controller for the Sl serial receiver: arms the receiver,
// synchronises its handshake, validates finished words and queues them for APB.
module sl_rx_ctrl
    import sl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = SL_CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cfgEnable,
    input  logic [4:0]                  cfgBitCount,
    output logic                        rxEnable,
    output logic [4:0]                  rxBitCount,
    input  logic                        rxWordInProces,
    input  logic                        rxWordReady,
    input  logic [SL_WORD_W-1:0]        rxData,
    input  logic                        rxParityValid,
    input  logic                        rxBitCountValid,
    output logic [SL_WORD_W-1:0]        rdData,
    output logic                        rdValid,
    input  logic                        rdReady,
    output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
    output logic [CNT_W-1:0]            parityErrCnt,
    output logic [CNT_W-1:0]            lenErrCnt,
    output logic                        overflowErr,
    input  logic                        errClear,
    output logic                        irq
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ARMED   = ARMED;
    localparam logic [1:0] ST_BUSY    = BUSY;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;

    logic [1:0]           state;
    logic [1:0]           stateNext;
    logic [1:0]           wipSync;
    logic [1:0]           wrSync;
    logic                 wrSyncD;
    logic                 wordEvt;
    logic                 wipBusy;
    logic                 capture;
    logic                 pushReq;
    logic [SL_WORD_W-1:0] pushData;
    logic                 pushDropped;
    logic                 parityInc;
    logic                 lenInc;

    // Two-flop synchronisers plus edge-detect history. The ready path resets
    // high so a line still high when reset is released is not taken as a new word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wipSync <= 2'b00;
            wrSync  <= 2'b11;
            wrSyncD <= 1'b1;
        end else begin
            wipSync <= {wipSync[0], rxWordInProces};
            wrSync  <= {wrSync[0], rxWordReady};
            wrSyncD <= wrSync[1];
        end
    end

    assign wordEvt = wrSync[1] & ~wrSyncD;
    assign wipBusy = wipSync[1];

    // Next-state decode; disable always wins and drops any word in flight.
    // NOTE: stateNext gets a default before the case so no path can infer a latch.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (cfgEnable) stateNext = ST_ARMED;
            end
            ST_ARMED: begin
                if (!cfgEnable)   stateNext = ST_IDLE;
                else if (wordEvt) stateNext = ST_CAPTURE;
                else if (wipBusy) stateNext = ST_BUSY;
            end
            ST_BUSY: begin
                if (!cfgEnable)   stateNext = ST_IDLE;
                else if (wordEvt) stateNext = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                stateNext = cfgEnable ? ST_ARMED : ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State register and word-length configuration; length is only picked up
    // when arming or while armed, so it stays frozen during a word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rxBitCount <= '0;
        end else begin
            state <= stateNext;
            if ((state == ST_IDLE && cfgEnable) || state == ST_ARMED)
                rxBitCount <= cfgBitCount;
        end
    end

    assign rxEnable  = (state != ST_IDLE);
    assign capture   = (state == ST_CAPTURE);
    assign pushReq   = capture & rxParityValid & rxBitCountValid;
    assign pushData  = slAlign(rxData, rxBitCount);
    assign parityInc = capture & ~rxParityValid;
    assign lenInc    = capture & ~rxBitCountValid;

    sl_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SL_WORD_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (pushReq),
        .pushData (pushData),
        .pop      (rdReady),
        .popData  (rdData),
        .count    (fifoLevel),
        .notEmpty (rdValid),
        .dropped  (pushDropped)
    );

    // Error counters, sticky overflow and the delayed interrupt; clear beats increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parityErrCnt <= '0;
            lenErrCnt    <= '0;
            overflowErr  <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (errClear) begin
                parityErrCnt <= '0;
                lenErrCnt    <= '0;
                overflowErr  <= 1'b0;
            end else begin
                if (parityInc && parityErrCnt != '1)
                    parityErrCnt <= parityErrCnt + CNT_W'(1);
                if (lenInc && lenErrCnt != '1)
                    lenErrCnt <= lenErrCnt + CNT_W'(1);
                if (pushDropped)
                    overflowErr <= 1'b1;
            end
            irq <= rdValid | overflowErr;
        end
    end

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Directed bench for sl_rx_ctrl: word capture and alignment, error counting,
// FIFO full/overflow, disable handling and asynchronous reset.
module tb_sl_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfgEnable;
    logic [4:0]  cfgBitCount;
    logic        rxEnable;
    logic [4:0]  rxBitCount;
    logic        rxWordInProces;
    logic        rxWordReady;
    logic [31:0] rxData;
    logic        rxParityValid;
    logic        rxBitCountValid;
    logic [31:0] rdData;
    logic        rdValid;
    logic        rdReady;
    logic [2:0]  fifoLevel;
    logic [1:0]  parityErrCnt;
    logic [1:0]  lenErrCnt;
    logic        overflowErr;
    logic        errClear;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Narrow counters keep the saturation case short.
    sl_rx_ctrl #(
        .FIFO_DEPTH (4),
        .CNT_W      (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfgEnable       (cfgEnable),
        .cfgBitCount     (cfgBitCount),
        .rxEnable        (rxEnable),
        .rxBitCount      (rxBitCount),
        .rxWordInProces  (rxWordInProces),
        .rxWordReady     (rxWordReady),
        .rxData          (rxData),
        .rxParityValid   (rxParityValid),
        .rxBitCountValid (rxBitCountValid),
        .rdData          (rdData),
        .rdValid         (rdValid),
        .rdReady         (rdReady),
        .fifoLevel       (fifoLevel),
        .parityErrCnt    (parityErrCnt),
        .lenErrCnt       (lenErrCnt),
        .overflowErr     (overflowErr),
        .errClear        (errClear),
        .irq             (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " rxEnable"},     32'(rxEnable),     32'd0);
        chk({tag, " rxBitCount"},   32'(rxBitCount),   32'd0);
        chk({tag, " rdValid"},      32'(rdValid),      32'd0);
        chk({tag, " rdData"},       rdData,            32'd0);
        chk({tag, " fifoLevel"},    32'(fifoLevel),    32'd0);
        chk({tag, " parityErrCnt"}, 32'(parityErrCnt), 32'd0);
        chk({tag, " lenErrCnt"},    32'(lenErrCnt),    32'd0);
        chk({tag, " overflowErr"},  32'(overflowErr),  32'd0);
        chk({tag, " irq"},          32'(irq),          32'd0);
    endtask

    // Called at a falling edge; pops once at the next rising edge.
    task automatic popOne();
        rdReady = 1'b1;
        @(negedge clk);
        rdReady = 1'b0;
    endtask

    // One receiver word. Called at a falling edge. Ready rises at e0; the
    // controller is in CAPTURE between falling edges e3 and e4, which is where
    // the optional clear/pop pulses are placed.
    task automatic sendWord(input logic [31:0] data, input logic par, input logic len,
                            input logic busy, input logic clrCap, input logic popCap);
        rxData          = data;
        rxParityValid   = par;
        rxBitCountValid = len;
        if (busy) begin
            rxWordInProces = 1'b1;
            repeat (4) @(negedge clk);
        end
        rxWordReady    = 1'b1;
        rxWordInProces = 1'b0;
        repeat (3) @(negedge clk);
        errClear = clrCap;
        rdReady  = popCap;
        @(negedge clk);
        errClear = 1'b0;
        rdReady  = 1'b0;
        repeat (2) @(negedge clk);
        rxWordReady = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n         = 1'b0;
        cfgEnable       = 1'b0;
        cfgBitCount     = 5'd7;
        rxWordInProces  = 1'b0;
        rxWordReady     = 1'b0;
        rxData          = 32'd0;
        rxParityValid   = 1'b0;
        rxBitCountValid = 1'b0;
        rdReady         = 1'b0;
        errClear        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chkAllZero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle rxEnable", 32'(rxEnable), 32'd0);
        cfgEnable = 1'b1;
        @(negedge clk);
        chk("armed rxEnable", 32'(rxEnable), 32'd1);
        chk("armed rxBitCount", 32'(rxBitCount), 32'd7);
        repeat (2) @(negedge clk);

        // 8-bit word with exact handshake latency
        rxData          = 32'hA500_0000;
        rxParityValid   = 1'b1;
        rxBitCountValid = 1'b1;
        rxWordReady     = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1 rdValid before N+3", 32'(rdValid), 32'd0);
        chk("t1 fifoLevel before N+3", 32'(fifoLevel), 32'd0);
        @(negedge clk);
        chk("t1 rdValid after N+3", 32'(rdValid), 32'd1);
        chk("t1 fifoLevel", 32'(fifoLevel), 32'd1);
        chk("t1 rdData", rdData, 32'h0000_00A5);
        chk("t1 irq after N+3", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t1 irq after N+4", 32'(irq), 32'd1);
        @(negedge clk);
        rxWordReady = 1'b0;
        repeat (3) @(negedge clk);
        popOne();
        chk("t1 pop level", 32'(fifoLevel), 32'd0);
        chk("t1 pop rdValid", 32'(rdValid), 32'd0);
        chk("t1 irq lags pop", 32'(irq), 32'd1);
        @(negedge clk);
        chk("t1 irq cleared", 32'(irq), 32'd0);

        // 15-bit word through the BUSY path
        cfgBitCount = 5'd14;
        @(negedge clk);
        chk("t2 rxBitCount tracks", 32'(rxBitCount), 32'd14);
        sendWord(32'hB554_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2 rdData", rdData, 32'h0000_5AAA);
        chk("t2 fifoLevel", 32'(fifoLevel), 32'd1);
        popOne();
        chk("t2 pop level", 32'(fifoLevel), 32'd0);
        @(negedge clk);
        chk("t2 irq clears", 32'(irq), 32'd0);
        popOne();
        chk("t2 empty pop level", 32'(fifoLevel), 32'd0);
        chk("t2 empty pop rdValid", 32'(rdValid), 32'd0);

        // Rejected words and counter saturation
        cfgBitCount = 5'd7;
        sendWord(32'h1100_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3 parity err 1", 32'(parityErrCnt), 32'd1);
        chk("t3 len err 0", 32'(lenErrCnt), 32'd0);
        chk("t3 no push", 32'(fifoLevel), 32'd0);
        sendWord(32'h2200_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3 parity err 2", 32'(parityErrCnt), 32'd2);
        chk("t3 len err 1", 32'(lenErrCnt), 32'd1);
        chk("t3 no push both bad", 32'(fifoLevel), 32'd0);
        sendWord(32'h3300_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3 parity err 3", 32'(parityErrCnt), 32'd3);
        sendWord(32'h4400_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3 parity saturates", 32'(parityErrCnt), 32'd3);
        chk("t3 irq quiet", 32'(irq), 32'd0);

        // Overflow: five words, no pops
        for (int k = 1; k <= 5; k++)
            sendWord(32'(k) << 24, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4 fifoLevel full", 32'(fifoLevel), 32'd4);
        chk("t4 overflowErr", 32'(overflowErr), 32'd1);
        chk("t4 irq", 32'(irq), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t4 pop word %0d", k), rdData, 32'(k));
            popOne();
        end
        chk("t4 drained", 32'(fifoLevel), 32'd0);
        chk("t4 overflow sticky", 32'(overflowErr), 32'd1);
        errClear = 1'b1;
        @(negedge clk);
        errClear = 1'b0;
        chk("t4 clr parity", 32'(parityErrCnt), 32'd0);
        chk("t4 clr len", 32'(lenErrCnt), 32'd0);
        chk("t4 clr overflow", 32'(overflowErr), 32'd0);
        @(negedge clk);
        chk("t4 irq after clear", 32'(irq), 32'd0);
        sendWord(32'h5500_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4 clear beats parity inc", 32'(parityErrCnt), 32'd0);
        chk("t4 clear beats len inc", 32'(lenErrCnt), 32'd0);

        // Disable while BUSY, then re-enable with a new length
        rxData          = 32'h7700_0000;
        rxParityValid   = 1'b0;
        rxBitCountValid = 1'b1;
        rxWordInProces  = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5 busy rxEnable", 32'(rxEnable), 32'd1);
        cfgBitCount = 5'd20;
        @(negedge clk);
        chk("t5 rxBitCount frozen", 32'(rxBitCount), 32'd7);
        cfgEnable = 1'b0;
        @(negedge clk);
        chk("t5 rxEnable dropped", 32'(rxEnable), 32'd0);
        rxWordReady    = 1'b1;
        rxWordInProces = 1'b0;
        repeat (5) @(negedge clk);
        rxWordReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 no push", 32'(fifoLevel), 32'd0);
        chk("t5 parity unchanged", 32'(parityErrCnt), 32'd0);
        chk("t5 len unchanged", 32'(lenErrCnt), 32'd0);
        cfgBitCount = 5'd3;
        cfgEnable   = 1'b1;
        @(negedge clk);
        chk("t5 re-enable rxEnable", 32'(rxEnable), 32'd1);
        chk("t5 re-enable rxBitCount", 32'(rxBitCount), 32'd3);

        // Full FIFO with simultaneous push and pop (4-bit words)
        for (int k = 1; k <= 4; k++)
            sendWord(32'(k) << 28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6 full", 32'(fifoLevel), 32'd4);
        sendWord(32'h5000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6 level held", 32'(fifoLevel), 32'd4);
        chk("t6 no overflow", 32'(overflowErr), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("t6 pop word %0d", k), rdData, 32'(k));
            popOne();
        end

        // Asynchronous reset in the middle of a word
        sendWord(32'h9000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t7 pre-reset level", 32'(fifoLevel), 32'd1);
        rxData          = 32'hC000_0000;
        rxParityValid   = 1'b1;
        rxBitCountValid = 1'b1;
        rxWordInProces  = 1'b1;
        repeat (4) @(negedge clk);
        rxWordReady = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chkAllZero("t7 mid-word reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t7 no stale capture level", 32'(fifoLevel), 32'd0);
        chk("t7 no stale capture rdValid", 32'(rdValid), 32'd0);
        rxWordReady    = 1'b0;
        rxWordInProces = 1'b0;
        repeat (3) @(negedge clk);
        sendWord(32'hC000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t7 fresh word data", rdData, 32'h0000_000C);
        chk("t7 fresh word level", 32'(fifoLevel), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
